// File: rtl/phase_sweep_controller_if.sv
// Bundle between the sweep controller and its register-side master.
// The slave side captures config on i_start and drives the accumulator-facing outputs.
interface phase_sweep_controller_if #(
    parameter int PHASE_W = 10,
    parameter int DWELL_W = 16
);
    logic               i_start;
    logic               i_abort;
    logic               i_mode;
    logic [PHASE_W-1:0] i_StartStep;
    logic [PHASE_W-1:0] i_StopStep;
    logic [PHASE_W-1:0] i_StepInc;
    logic [DWELL_W-1:0] i_Dwell;

    logic [PHASE_W-1:0] o_PhaseStep;
    logic               o_AccRst_n;
    logic               o_Busy;
    logic               o_Wrap;
    logic               o_Done;

    modport master (
        output i_start, i_abort, i_mode, i_StartStep, i_StopStep, i_StepInc, i_Dwell,
        input  o_PhaseStep, o_AccRst_n, o_Busy, o_Wrap, o_Done
    );

    modport slave (
        input  i_start, i_abort, i_mode, i_StartStep, i_StopStep, i_StepInc, i_Dwell,
        output o_PhaseStep, o_AccRst_n, o_Busy, o_Wrap, o_Done
    );
endinterface

// File: rtl/phase_sweep_controller.sv
// Chirp sequencer: steps the accumulator phase-step from StartStep towards StopStep by StepInc,
// holding each step Dwell+1 cycles; single-shot or repeating. Every output is registered.
module phase_sweep_controller #(
    parameter int PHASE_W = 10,
    parameter int DWELL_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    phase_sweep_controller_if.slave sweep
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;

    // Shadow copy of the configuration, frozen for the whole sweep
    logic               mode_q, mode_d;
    logic [PHASE_W-1:0] start_step_q, start_step_d;
    logic [PHASE_W-1:0] stop_step_q, stop_step_d;
    logic [PHASE_W-1:0] step_inc_q, step_inc_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic [PHASE_W-1:0] step_q, step_d;
    logic               acc_rst_n_q, acc_rst_n_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;

    logic [PHASE_W:0]   next_sum;
    logic               sweep_end;
    logic               dwell_end;

    // One extra bit so a step that overflows the accumulator width ends the sweep
    assign next_sum  = {1'b0, step_q} + {1'b0, step_inc_q};
    assign sweep_end = (step_inc_q == '0) || next_sum[PHASE_W] || (next_sum > {1'b0, stop_step_q});
    assign dwell_end = (cnt_q == dwell_q);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        start_step_d = start_step_q;
        stop_step_d  = stop_step_q;
        step_inc_d   = step_inc_q;
        dwell_d      = dwell_q;
        cnt_d        = cnt_q;
        step_d       = step_q;
        acc_rst_n_d  = 1'b1;
        wrap_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                step_d = '0;
                if (sweep.i_start && !sweep.i_abort) begin
                    mode_d       = sweep.i_mode;
                    start_step_d = sweep.i_StartStep;
                    stop_step_d  = sweep.i_StopStep;
                    step_inc_d   = sweep.i_StepInc;
                    dwell_d      = sweep.i_Dwell;
                    cnt_d        = '0;
                    step_d       = sweep.i_StartStep;
                    acc_rst_n_d  = 1'b0;
                    state_d      = ST_LOAD;
                end
            end

            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_DWELL;
            end

            ST_DWELL: begin
                if (dwell_end) begin
                    cnt_d = '0;
                    if (!sweep_end) begin
                        step_d = next_sum[PHASE_W-1:0];
                    end else if (mode_q) begin
                        // Wrap without resetting the accumulator keeps phase continuous
                        step_d = start_step_q;
                        wrap_d = 1'b1;
                    end else begin
                        step_d  = '0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                step_d  = '0;
                state_d = ST_IDLE;
            end

            default: begin
                step_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (sweep.i_abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            step_d      = '0;
            acc_rst_n_d = 1'b1;
            wrap_d      = 1'b0;
            done_d      = 1'b0;
        end

        busy_d = (state_d == ST_LOAD) || (state_d == ST_DWELL);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= 1'b0;
            start_step_q <= '0;
            stop_step_q  <= '0;
            step_inc_q   <= '0;
            dwell_q      <= '0;
            cnt_q        <= '0;
            step_q       <= '0;
            acc_rst_n_q  <= 1'b1;
            busy_q       <= 1'b0;
            wrap_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            start_step_q <= start_step_d;
            stop_step_q  <= stop_step_d;
            step_inc_q   <= step_inc_d;
            dwell_q      <= dwell_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            acc_rst_n_q  <= acc_rst_n_d;
            busy_q       <= busy_d;
            wrap_q       <= wrap_d;
            done_q       <= done_d;
        end
    end

    assign sweep.o_PhaseStep = step_q;
    assign sweep.o_AccRst_n  = acc_rst_n_q;
    assign sweep.o_Busy      = busy_q;
    assign sweep.o_Wrap      = wrap_q;
    assign sweep.o_Done      = done_q;

endmodule

// File: tb/tb_phase_sweep_controller.sv
// Directed bench for phase_sweep_controller: stimulus pushes hand-computed per-cycle
// expectations into a queue, and a negedge monitor pops and compares them.
module tb_phase_sweep_controller;

    logic clk;
    logic rst_n;

    phase_sweep_controller_if #(.PHASE_W(10), .DWELL_W(16)) sif ();

    phase_sweep_controller #(.PHASE_W(10), .DWELL_W(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .sweep   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [9:0] step;
        logic       rstn;
        logic       busy;
        logic       wrap;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   idx   = 0;

    task automatic push(input string tag, input int step, input bit rstn, input bit busy,
                        input bit wrap, input bit done, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.tag  = tag;
            e.step = step[9:0];
            e.rstn = rstn;
            e.busy = busy;
            e.wrap = wrap;
            e.done = done;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_idle(input string tag, input int n);
        push(tag, 0, 1'b1, 1'b0, 1'b0, 1'b0, n);
    endtask

    task automatic push_load(input string tag, input int step);
        push(tag, step, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    endtask

    task automatic push_dw(input string tag, input int step, input int n);
        push(tag, step, 1'b1, 1'b1, 1'b0, 1'b0, n);
    endtask

    task automatic push_wrap(input string tag, input int step);
        push(tag, step, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    endtask

    task automatic push_done(input string tag);
        push(tag, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    endtask

    // Monitor: one comparison per cycle whenever an expectation is pending
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (sif.o_PhaseStep !== e.step || sif.o_AccRst_n !== e.rstn || sif.o_Busy !== e.busy ||
                sif.o_Wrap !== e.wrap || sif.o_Done !== e.done) begin
                bad++;
                $display("FAIL %s[%0d]: got step=%0d accrst_n=%b busy=%b wrap=%b done=%b, want step=%0d accrst_n=%b busy=%b wrap=%b done=%b",
                         e.tag, idx, sif.o_PhaseStep, sif.o_AccRst_n, sif.o_Busy, sif.o_Wrap, sif.o_Done,
                         e.step, e.rstn, e.busy, e.wrap, e.done);
            end else begin
                $display("ok   %s[%0d]: step=%0d accrst_n=%b busy=%b wrap=%b done=%b",
                         e.tag, idx, sif.o_PhaseStep, sif.o_AccRst_n, sif.o_Busy, sif.o_Wrap, sif.o_Done);
            end
            idx++;
        end else begin
            idx = 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int s, input int p, input int inc, input int d, input bit m);
        sif.i_StartStep = s[9:0];
        sif.i_StopStep  = p[9:0];
        sif.i_StepInc   = inc[9:0];
        sif.i_Dwell     = d[15:0];
        sif.i_mode      = m;
    endtask

    // Start pulse during cycle 0; returns at cycle 1
    task automatic pulse_start();
        sif.i_start = 1'b1;
        next_cycle();
        sif.i_start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s drain: got %0d pending expectations, want 0", tag, exp_q.size());
            exp_q.delete();
        end
        next_cycle();
    endtask

    // Expected trace of the Start=4 Stop=10 Inc=3 Dwell=1 single sweep
    task automatic push_s1(input string tag);
        push_idle(tag, 1);
        push_load(tag, 4);
        push_dw(tag, 4, 2);
        push_dw(tag, 7, 2);
        push_dw(tag, 10, 2);
        push_done(tag);
        push_idle(tag, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        sif.i_start   = 1'b0;
        sif.i_abort   = 1'b0;
        cfg(0, 0, 0, 0, 1'b0);

        push_idle("reset", 3);
        #22 rst_n = 1'b1;
        wait_drain("reset");

        // Single sweep, config scrambled mid-sweep must have no effect
        cfg(4, 10, 3, 1, 1'b0);
        push_s1("single");
        pulse_start();
        cfg(0, 1023, 1, 0, 1'b1);
        wait_drain("single");

        // Overflow: 1040 does not fit 10 bits, sweep ends
        cfg(1000, 1023, 20, 0, 1'b0);
        push_idle("ovf", 1);
        push_load("ovf", 1000);
        push_dw("ovf", 1000, 1);
        push_dw("ovf", 1020, 1);
        push_done("ovf");
        push_idle("ovf", 2);
        pulse_start();
        wait_drain("ovf");

        // Repeat mode, aborted during cycle 9
        cfg(2, 6, 2, 0, 1'b1);
        push_idle("repeat", 1);
        push_load("repeat", 2);
        push_dw("repeat", 2, 1);
        push_dw("repeat", 4, 1);
        push_dw("repeat", 6, 1);
        push_wrap("repeat", 2);
        push_dw("repeat", 4, 1);
        push_dw("repeat", 6, 1);
        push_wrap("repeat", 2);
        push_dw("repeat", 4, 1);
        push_idle("repeat", 3);
        pulse_start();
        repeat (8) next_cycle();
        sif.i_abort = 1'b1;
        next_cycle();
        sif.i_abort = 1'b0;
        wait_drain("repeat");

        // Abort during cycle 5 of the single sweep
        cfg(4, 10, 3, 1, 1'b0);
        push_idle("abort", 1);
        push_load("abort", 4);
        push_dw("abort", 4, 2);
        push_dw("abort", 7, 2);
        push_idle("abort", 5);
        pulse_start();
        repeat (4) next_cycle();
        sif.i_abort = 1'b1;
        next_cycle();
        sif.i_abort = 1'b0;
        wait_drain("abort");

        // Abort together with start in IDLE: nothing happens
        push_idle("abort_start", 4);
        sif.i_abort = 1'b1;
        pulse_start();
        sif.i_abort = 1'b0;
        wait_drain("abort_start");

        // Zero increment
        cfg(5, 20, 0, 3, 1'b0);
        push_idle("inc0", 1);
        push_load("inc0", 5);
        push_dw("inc0", 5, 4);
        push_done("inc0");
        push_idle("inc0", 2);
        pulse_start();
        wait_drain("inc0");

        // StartStep above StopStep, single
        cfg(500, 100, 1, 0, 1'b0);
        push_idle("inv", 1);
        push_load("inv", 500);
        push_dw("inv", 500, 1);
        push_done("inv");
        push_idle("inv", 2);
        pulse_start();
        wait_drain("inv");

        // StartStep above StopStep, repeat: wraps every dwell, then abort
        cfg(500, 100, 1, 0, 1'b1);
        push_idle("inv_rep", 1);
        push_load("inv_rep", 500);
        push_dw("inv_rep", 500, 1);
        push_wrap("inv_rep", 500);
        push_wrap("inv_rep", 500);
        push_idle("inv_rep", 2);
        pulse_start();
        repeat (3) next_cycle();
        sif.i_abort = 1'b1;
        next_cycle();
        sif.i_abort = 1'b0;
        wait_drain("inv_rep");

        // Asynchronous reset between edges in cycle 4, then a clean sweep
        cfg(4, 10, 3, 1, 1'b0);
        push_idle("areset", 1);
        push_load("areset", 4);
        push_dw("areset", 4, 2);
        push_idle("areset", 3);
        pulse_start();
        repeat (3) next_cycle();
        #1 rst_n = 1'b0;
        next_cycle();
        #1 rst_n = 1'b1;
        wait_drain("areset");

        push_s1("post_reset");
        pulse_start();
        wait_drain("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
